// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, ALU control and FSM state encodings
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctl_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEMADDR,
    S_MEMRD, S_WB_MEM, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE: return S_EXEC_R;
      OP_LW, OP_SW: return S_MEMADDR;
      OP_BEQ: return S_BRANCH;
      OP_ADDI: return S_EXEC_I;
      OP_J: return S_JUMP;
      default: return S_TRAP;
    endcase
  endfunction
  function automatic alu_ctl_t funct_ctl(input logic [5:0] f);
    case (f)
      F_SUB: return ALU_SUB;
      F_AND: return ALU_AND;
      F_OR: return ALU_OR;
      F_SLT: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction
  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction
endpackage

// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if: unified req/ready memory port shared by fetch and data accesses
interface mips_multicycle_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: 32-entry register file, two async reads, one clocked write, $0 reads zero
module mips_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] rf [32];
  // writes to $0 are dropped so it stays architecturally zero
  always_ff @(posedge Clk) if (we && wa != 5'd0) rf[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : rf[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : rf[ra2];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset with one shared ALU and a single req/ready memory port
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  mips_multicycle_core_if.master bus,
  output logic                  retire,
  output logic [ADDR_W-1:0]     pc_out,
  output logic                  trap
);
  state_t state, state_n;
  alu_ctl_t alu_ctl;
  logic [ADDR_W-1:0] pc, pc_n, issue_addr;
  logic [31:0] ir;
  logic [DATA_W-1:0] a, b, aluout, mdr, rd1, rd2, rf_wd;
  logic [DATA_W-1:0] sext_imm, pc_ext, jt_w, alu_a, alu_b, alu_y;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, rf_wa;
  logic issue, issue_we, done, rf_we;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign funct = ir[5:0];
  assign sext_imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign pc_ext = DATA_W'(pc);
  assign jt_w = {pc_ext[DATA_W-1:28], ir[25:0], 2'b00};
  assign done = bus.mem_req && bus.mem_ready;
  assign issue_we = state == S_MEMADDR && op == OP_SW;
  assign issue_addr = state == S_MEMADDR ? alu_y[ADDR_W-1:0] : pc_n;
  assign pc_out = pc;
  assign trap = state == S_TRAP;
  assign rf_we = !Rst && state inside {S_WB_R, S_WB_I, S_WB_MEM};
  assign rf_wa = state == S_WB_R ? rd : rt;
  assign rf_wd = state == S_WB_MEM ? mdr : aluout;

  mips_regfile #(.DATA_W(DATA_W)) u_rf (
    .Clk(Clk), .we(rf_we), .wa(rf_wa), .wd(rf_wd),
    .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
  );

  // shared ALU: branch target in DECODE, address/immediate add, and R-type ops
  always_comb begin
    alu_a = state == S_DECODE ? pc_ext : a;
    alu_b = state == S_DECODE ? {sext_imm[DATA_W-3:0], 2'b00} : state == S_EXEC_R ? b : sext_imm;
    alu_ctl = state == S_EXEC_R ? funct_ctl(funct) : ALU_ADD;
    alu_y = alu_ctl == ALU_SUB ? alu_a - alu_b :
            alu_ctl == ALU_AND ? alu_a & alu_b :
            alu_ctl == ALU_OR  ? alu_a | alu_b :
            alu_ctl == ALU_SLT ? DATA_W'($signed(alu_a) < $signed(alu_b)) : alu_a + alu_b;
  end

  // next state, next PC, retire strobe and new memory access requests
  always_comb begin
    state_n = state;
    pc_n = pc;
    issue = 1'b0;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        issue = !bus.mem_req;
        state_n = done ? S_DECODE : S_FETCH;
        pc_n = done ? pc + ADDR_W'(4) : pc;
      end
      S_DECODE: state_n = dispatch(op);
      S_EXEC_R: state_n = funct_ok(funct) ? S_WB_R : S_TRAP;
      S_EXEC_I: state_n = S_WB_I;
      S_MEMADDR: begin
        state_n = |alu_y[1:0] ? S_TRAP : op == OP_SW ? S_MEMWR : S_MEMRD;
        issue = ~|alu_y[1:0];
      end
      S_MEMRD: state_n = done ? S_WB_MEM : S_MEMRD;
      S_MEMWR: begin
        retire = done;
        issue = done;
        state_n = done ? S_FETCH : S_MEMWR;
      end
      S_WB_R, S_WB_I, S_WB_MEM: begin
        retire = 1'b1;
        issue = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        retire = 1'b1;
        issue = 1'b1;
        state_n = S_FETCH;
        pc_n = a == b ? aluout[ADDR_W-1:0] : pc;
      end
      S_JUMP: begin
        retire = 1'b1;
        issue = 1'b1;
        state_n = S_FETCH;
        pc_n = jt_w[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // architectural and datapath registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      aluout <= '0;
      mdr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (state == S_FETCH && done) ir <= bus.mem_rdata[31:0];
      if (state == S_DECODE) begin
        a <= rd1;
        b <= rd2;
      end
      if (state inside {S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADDR}) aluout <= alu_y;
      if (state == S_MEMRD && done) mdr <= bus.mem_rdata;
    end
  end

  // memory request registers: held until ready, dropped unless a new access starts
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else if (issue) begin
      bus.mem_req <= 1'b1;
      bus.mem_we <= issue_we;
      bus.mem_addr <= issue_addr;
      bus.mem_wdata <= b;
    end else if (done) begin
      bus.mem_req <= 1'b0;
    end
  end
endmodule
